// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: captures a packed ROWS x COLS matrix on a load pulse
// and streams it out one signed element per valid/ready handshake, tagged with
// its row/column and a last flag, then pulses done.
// Optional build macro: MAT_STREAM_COLMAJOR_EN selects column-major emission
// order (default build is row-major). Packing of mat_in is the same either way.
module matrix_result_streamer #(
  parameter  int ROWS    = 2,
  parameter  int COLS    = 2,
  parameter  int ELEM_W  = 8,
  localparam int N       = ROWS * COLS,
  localparam int MAT_LEN = N * ELEM_W,
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAT_LEN-1:0] mat_in,
  input  logic               load,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ELEM_W-1:0]  out_data,
  output logic [RW-1:0]      out_row,
  output logic [CW-1:0]      out_col,
  output logic               out_last,
  output logic               done
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state;
  logic [MAT_LEN-1:0] cap;
  logic [RW-1:0]      nxt_row;
  logic [CW-1:0]      nxt_col;

  // Element (r,c) lives at idx = r*COLS+c, with element (0,0) in the MSBs.
  function automatic logic [ELEM_W-1:0] pick(input logic [MAT_LEN-1:0] m,
                                             input logic [RW-1:0]      r,
                                             input logic [CW-1:0]      c);
    int idx;
    idx = int'(r) * COLS + int'(c);
    return m[ELEM_W*(N-1-idx) +: ELEM_W];
  endfunction

  function automatic logic is_last(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return (r == RW'(ROWS - 1)) && (c == CW'(COLS - 1));
  endfunction

  // Position of the element that follows the one currently presented.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    nxt_row = out_row;
    nxt_col = out_col;
`ifdef MAT_STREAM_COLMAJOR_EN
    if (out_row == RW'(ROWS - 1)) begin
      nxt_row = '0;
      nxt_col = out_col + 1'b1;
    end else begin
      nxt_row = out_row + 1'b1;
    end
`else
    if (out_col == CW'(COLS - 1)) begin
      nxt_col = '0;
      nxt_row = out_row + 1'b1;
    end else begin
      nxt_col = out_col + 1'b1;
    end
`endif
  end

  // Control FSM with registered stream outputs and capture register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state     <= IDLE;
      // NOTE: the capture register is cleared too, so no stale matrix survives reset.
      cap       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            cap       <= mat_in;
            out_data  <= mat_in[MAT_LEN-1 -: ELEM_W];
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= (N == 1);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              out_row  <= nxt_row;
              out_col  <= nxt_col;
              out_data <= pick(cap, nxt_row, nxt_col);
              out_last <= is_last(nxt_row, nxt_col);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer: randomized self-checking bench for
// matrix_result_streamer. Three instances (2x2x8, 1x1x16, 2x3x8) are checked
// against an index-based reference model of the emission order. Honours
// MAT_STREAM_COLMAJOR_EN when the design is built with it.
module tb_matrix_result_streamer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---- dut_a: 2x2, 8-bit ----
  logic [31:0] mat_a = '0;
  logic        load_a = 1'b0, ready_a = 1'b0;
  logic        busy_a, valid_a, last_a, done_a, row_a, col_a;
  logic [7:0]  data_a;

  matrix_result_streamer #(.ROWS(2), .COLS(2), .ELEM_W(8)) dut_a (
    .clk(clk), .rst(rst), .mat_in(mat_a), .load(load_a), .busy(busy_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
    .out_row(row_a), .out_col(col_a), .out_last(last_a), .done(done_a));

  // ---- dut_b: 1x1, 16-bit ----
  logic [15:0] mat_b = '0;
  logic        load_b = 1'b0, ready_b = 1'b0;
  logic        busy_b, valid_b, last_b, done_b, row_b, col_b;
  logic [15:0] data_b;

  matrix_result_streamer #(.ROWS(1), .COLS(1), .ELEM_W(16)) dut_b (
    .clk(clk), .rst(rst), .mat_in(mat_b), .load(load_b), .busy(busy_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
    .out_row(row_b), .out_col(col_b), .out_last(last_b), .done(done_b));

  // ---- dut_c: 2x3, 8-bit ----
  logic [47:0] mat_c = '0;
  logic        load_c = 1'b0, ready_c = 1'b0;
  logic        busy_c, valid_c, last_c, done_c, row_c;
  logic [1:0]  col_c;
  logic [7:0]  data_c;

  matrix_result_streamer #(.ROWS(2), .COLS(3), .ELEM_W(8)) dut_c (
    .clk(clk), .rst(rst), .mat_in(mat_c), .load(load_c), .busy(busy_c),
    .out_valid(valid_c), .out_ready(ready_c), .out_data(data_c),
    .out_row(row_c), .out_col(col_c), .out_last(last_c), .done(done_c));

  typedef struct {
    logic [63:0] data;
    int          row;
    int          col;
    logic        last;
  } elem_t;

  // k-th emitted element of a matrix: order decides (row,col), packing decides data.
  function automatic elem_t model(input logic [127:0] m, input int rows, input int cols,
                                  input int ew, input int k);
    elem_t e;
    int    idx;
`ifdef MAT_STREAM_COLMAJOR_EN
    e.row = k % rows;
    e.col = k / rows;
`else
    e.row = k / cols;
    e.col = k % cols;
`endif
    idx    = e.row * cols + e.col;
    e.data = 64'((m >> (ew * (rows * cols - 1 - idx))) & ((128'd1 << ew) - 1));
    e.last = (k == rows * cols - 1);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream one matrix through dut_a. abort_at: reset once that many handshakes
  // are done (-1: never). stall_at: hold ready low 3 cycles on that element.
  task automatic run_a(input logic [31:0] m, input bit noisy, input int abort_at,
                       input int stall_at);
    int    k = 0, cyc = 0, stalls = 0;
    bit    hs;
    elem_t e;
    mat_a  = m;
    load_a = 1'b1;
    @(posedge clk); #1;
    load_a = 1'b0;
    while (k < 4 && cyc < 100) begin
      if (k == abort_at) begin
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ready_a = 1'b0;
        check("a_abort_valid", valid_a, 0);
        check("a_abort_busy", busy_a, 0);
        check("a_abort_done", done_a, 0);
        @(posedge clk); #1;
        check("a_abort_nodone", done_a, 0);
        return;
      end
      e = model(m, 2, 2, 8, k);
      check("a_valid", valid_a, 1);
      check("a_busy", busy_a, 1);
      check("a_done_low", done_a, 0);
      check("a_data", data_a, e.data);
      check("a_row", row_a, e.row);
      check("a_col", col_a, e.col);
      check("a_last", last_a, e.last);
      if (k == stall_at && stalls < 3) begin
        ready_a = 1'b0;
        stalls++;
      end else begin
        ready_a = ($urandom_range(0, 3) != 0);
      end
      hs = ready_a;
      if (noisy) begin
        load_a = 1'($urandom_range(0, 1));
        mat_a  = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
      if (hs) k++;
    end
    ready_a = 1'b0;
    load_a  = 1'b0;
    check("a_timeout", (cyc < 100), 1);
    check("a_done_pulse", done_a, 1);
    check("a_valid_end", valid_a, 0);
    check("a_busy_end", busy_a, 0);
  endtask

  // Stream one matrix through dut_c with random backpressure.
  task automatic run_c(input logic [47:0] m);
    int    k = 0, cyc = 0;
    bit    hs;
    elem_t e;
    mat_c  = m;
    load_c = 1'b1;
    @(posedge clk); #1;
    load_c = 1'b0;
    mat_c  = {$urandom, $urandom};
    while (k < 6 && cyc < 100) begin
      e = model(m, 2, 3, 8, k);
      check("c_valid", valid_c, 1);
      check("c_data", data_c, e.data);
      check("c_row", row_c, e.row);
      check("c_col", col_c, e.col);
      check("c_last", last_c, e.last);
      ready_c = ($urandom_range(0, 2) != 0);
      hs = ready_c;
      @(posedge clk); #1;
      cyc++;
      if (hs) k++;
    end
    ready_c = 1'b0;
    check("c_timeout", (cyc < 100), 1);
    check("c_done_pulse", done_c, 1);
    check("c_busy_end", busy_c, 0);
    @(posedge clk); #1;
    check("c_done_once", done_c, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_busy", busy_a, 0);
    check("rst_a_valid", valid_a, 0);
    check("rst_a_last", last_a, 0);
    check("rst_a_done", done_a, 0);
    check("rst_a_data", data_a, 0);
    check("rst_a_row", row_a, 0);
    check("rst_a_col", col_a, 0);
    check("rst_b_valid", valid_b, 0);
    check("rst_c_valid", valid_c, 0);
    check("rst_c_data", data_c, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_a_valid", valid_a, 0);

    // Basic stream, then backpressure on the second element.
    run_a(32'h01020304, 1'b0, -1, -1);
    @(posedge clk); #1;
    check("a_done_one_cycle", done_a, 0);
    run_a(32'h01020304, 1'b0, -1, 1);
    @(posedge clk); #1;
    // Signed values with ignored loads and changing mat_in during the stream.
    run_a(32'hFF80_7F00, 1'b1, -1, -1);
    @(posedge clk); #1;
    check("a_single_done", done_a, 0);
    // Reset after the second handshake, then a fresh stream from (0,0).
    run_a($urandom, 1'b0, 2, -1);
    run_a($urandom, 1'b0, -1, -1);
    // Random matrices, sometimes back-to-back (load in the done cycle).
    for (int i = 0; i < 20; i++) begin
      run_a($urandom, 1'(i % 3 == 0), -1, -1);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
        check("a_idle_done", done_a, 0);
        check("a_idle_valid", valid_a, 0);
      end
    end

    // 1x1, 16-bit: single element is last; reload during done cycle.
    mat_b  = 16'h8001;
    load_b = 1'b1;
    @(posedge clk); #1;
    load_b = 1'b0;
    mat_b  = 16'h0000;
    check("b_valid", valid_b, 1);
    check("b_data", data_b, 16'h8001);
    check("b_last", last_b, 1);
    check("b_row", row_b, 0);
    check("b_col", col_b, 0);
    ready_b = 1'b1;
    @(posedge clk); #1;
    ready_b = 1'b0;
    check("b_done", done_b, 1);
    check("b_valid_end", valid_b, 0);
    mat_b  = 16'h7FFE;
    load_b = 1'b1;
    @(posedge clk); #1;
    load_b = 1'b0;
    check("b2_valid", valid_b, 1);
    check("b2_data", data_b, 16'h7FFE);
    check("b2_done_low", done_b, 0);
    ready_b = 1'b1;
    @(posedge clk); #1;
    ready_b = 1'b0;
    check("b2_done", done_b, 1);

    // 2x3: exercises the order in both build variants.
    run_c(48'h010203040506);
    for (int i = 0; i < 6; i++) run_c({$urandom, $urandom});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
